// File: rtl/contrast_param_engine_pkg.sv
// Shared types for the contrast parameter engine: FSM states, CSD term record
// and the unity-gain term used to seed both banks at reset.
package contrast_param_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_DONE
    } cpe_state_t;

    localparam int unsigned CPE_SHIFT_MAX_W = 8;

    typedef struct packed {
        logic                       en;
        logic                       neg;
        logic [CPE_SHIFT_MAX_W-1:0] shift;
    } cpe_term_t;

    function automatic cpe_term_t cpe_unity_term(input int unsigned frac_w);
        cpe_term_t t;
        t.en    = 1'b1;
        t.neg   = 1'b0;
        t.shift = CPE_SHIFT_MAX_W'(frac_w);
        return t;
    endfunction

endpackage

// File: rtl/contrast_param_engine_csd.sv
// Serial CSD recoder: one digit per step, LSB first; nonzero digits fill term
// slots in ascending shift order and overflow is flagged when slots run out.
module csd_serial_recoder #(
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_TERMS = 3,
    parameter int unsigned SHIFT_W   = 4,
    parameter int unsigned TERM_W    = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic                        step_i,
    input  logic [W-1:0]                data_i,
    output logic [MAX_TERMS*TERM_W-1:0] terms_o,
    output logic                        ovf_o,
    output logic                        done_o
);

    localparam int unsigned SLOT_W = $clog2(MAX_TERMS + 1);
    localparam logic [W:0]  ONE_V  = (W + 1)'(1);

    logic [W:0]                  v_q, v_d;
    logic [SHIFT_W-1:0]          cnt_q, cnt_d;
    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic [MAX_TERMS*TERM_W-1:0] terms_q, terms_d;
    logic                        ovf_q, ovf_d;
    logic                        nz, neg;
    logic [TERM_W-1:0]           term;

    always_comb begin
        v_d     = v_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        terms_d = terms_q;
        ovf_d   = ovf_q;
        nz      = v_q[0];
        neg     = v_q[1] & v_q[0];
        term    = {1'b1, neg, cnt_q};
        if (start_i) begin
            v_d     = {1'b0, data_i};
            cnt_d   = '0;
            slot_d  = '0;
            terms_d = '0;
            ovf_d   = 1'b0;
        end else if (step_i) begin
            cnt_d = cnt_q + SHIFT_W'(1);
            // Removing the emitted digit before halving keeps v non-negative.
            if (!nz)      v_d = v_q >> 1;
            else if (neg) v_d = (v_q + ONE_V) >> 1;
            else          v_d = (v_q - ONE_V) >> 1;
            if (nz) begin
                if (slot_q == SLOT_W'(MAX_TERMS)) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int unsigned s = 0; s < MAX_TERMS; s++) begin
                        if (slot_q == SLOT_W'(s)) terms_d[s*TERM_W +: TERM_W] = term;
                    end
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            terms_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            terms_q <= terms_d;
            ovf_q   <= ovf_d;
        end
    end

    assign terms_o = terms_q;
    assign ovf_o   = ovf_q;
    assign done_o  = step_i && (cnt_q == SHIFT_W'(W));

endmodule

// File: rtl/contrast_param_engine.sv
// Per-channel contrast parameter engine: serial CSD conversion into a shadow
// bank, committed to the active bank on frame_start.
module contrast_param_engine
    import contrast_param_engine_pkg::*;
#(
    parameter int unsigned  CH_NUM    = 3,
    parameter int unsigned  W         = 8,
    parameter int unsigned  FRAC_W    = 3,
    parameter int unsigned  MAX_TERMS = 3,
    localparam int unsigned SHIFT_W   = $clog2(W + 1),
    localparam int unsigned TERM_W    = SHIFT_W + 2,
    localparam int unsigned CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [CH_W-1:0]                    wr_ch,
    input  logic [W-1:0]                       wr_data,
    output logic                               wr_ready,
    input  logic                               frame_start,
    output logic [CH_NUM*W-1:0]                contrast_fp,
    output logic [CH_NUM*MAX_TERMS*TERM_W-1:0] cp_param,
    output logic                               invalid,
    output logic [CH_W-1:0]                    err_ch
);

    localparam int unsigned             TV_W        = MAX_TERMS * TERM_W;
    localparam cpe_term_t               UNITY       = cpe_unity_term(FRAC_W);
    localparam logic [TERM_W-1:0]       UNITY_TERM  = {UNITY.en, UNITY.neg, UNITY.shift[SHIFT_W-1:0]};
    localparam logic [TV_W-1:0]         UNITY_TERMS = TV_W'(UNITY_TERM);
    localparam logic [W-1:0]            UNITY_VAL   = W'(1) << FRAC_W;
    localparam logic [CH_W:0]           CH_LIMIT    = (CH_W + 1)'(CH_NUM);

    cpe_state_t                 state_q, state_d;
    logic [CH_W-1:0]            ch_q, ch_d, err_ch_q, err_ch_d;
    logic [W-1:0]               val_q, val_d;
    logic [CH_NUM*W-1:0]        act_val_q, act_val_d, shd_val_q, shd_val_d;
    logic [CH_NUM*TV_W-1:0]     act_terms_q, act_terms_d, shd_terms_q, shd_terms_d;
    logic [CH_NUM-1:0]          pending_q, pending_d;
    logic                       invalid_q, invalid_d;
    logic                       rec_start, rec_step, resolve, rec_done, rec_ovf, write_ok;
    logic [TV_W-1:0]            rec_terms;

    csd_serial_recoder #(
        .W         (W),
        .MAX_TERMS (MAX_TERMS),
        .SHIFT_W   (SHIFT_W),
        .TERM_W    (TERM_W)
    ) u_recoder (
        .clk     (clk),
        .reset   (reset),
        .start_i (rec_start),
        .step_i  (rec_step),
        .data_i  (wr_data),
        .terms_o (rec_terms),
        .ovf_o   (rec_ovf),
        .done_o  (rec_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (wr_en)    state_d = ST_CONVERT;
            ST_CONVERT: if (rec_done) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ready  = (state_q == ST_IDLE);
        rec_start = (state_q == ST_IDLE) && wr_en;
        rec_step  = (state_q == ST_CONVERT);
        resolve   = (state_q == ST_DONE);
    end

    assign write_ok = resolve && !rec_ovf && ({1'b0, ch_q} < CH_LIMIT);

    always_comb begin
        ch_d        = rec_start ? wr_ch : ch_q;
        val_d       = rec_start ? wr_data : val_q;
        act_val_d   = act_val_q;
        act_terms_d = act_terms_q;
        shd_val_d   = shd_val_q;
        shd_terms_d = shd_terms_q;
        pending_d   = pending_q;
        invalid_d   = resolve && !write_ok;
        err_ch_d    = (resolve && !write_ok) ? ch_q : err_ch_q;
        if (frame_start) begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                if (pending_q[c]) begin
                    act_val_d[c*W +: W]         = shd_val_q[c*W +: W];
                    act_terms_d[c*TV_W +: TV_W] = shd_terms_q[c*TV_W +: TV_W];
                    pending_d[c]                = 1'b0;
                end
            end
        end
        // Applied after the commit so a same-edge write stays pending for the next frame.
        if (write_ok) begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                if (ch_q == CH_W'(c)) begin
                    shd_val_d[c*W +: W]         = val_q;
                    shd_terms_d[c*TV_W +: TV_W] = rec_terms;
                    pending_d[c]                = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q        <= '0;
            val_q       <= '0;
            act_val_q   <= {CH_NUM{UNITY_VAL}};
            shd_val_q   <= {CH_NUM{UNITY_VAL}};
            act_terms_q <= {CH_NUM{UNITY_TERMS}};
            shd_terms_q <= {CH_NUM{UNITY_TERMS}};
            pending_q   <= '0;
            invalid_q   <= 1'b0;
            err_ch_q    <= '0;
        end else begin
            ch_q        <= ch_d;
            val_q       <= val_d;
            act_val_q   <= act_val_d;
            shd_val_q   <= shd_val_d;
            act_terms_q <= act_terms_d;
            shd_terms_q <= shd_terms_d;
            pending_q   <= pending_d;
            invalid_q   <= invalid_d;
            err_ch_q    <= err_ch_d;
        end
    end

    assign contrast_fp = act_val_q;
    assign cp_param    = act_terms_q;
    assign invalid     = invalid_q;
    assign err_ch      = err_ch_q;

endmodule

// File: tb/tb_contrast_param_engine.sv
// Bench for contrast_param_engine: transaction-level model checked every cycle
// plus directed literal expectations.
module tb_contrast_param_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        frame_start = 1'b0;
    logic [23:0] contrast_fp;
    logic [53:0] cp_param;
    logic        invalid;
    logic [1:0]  err_ch;

    int n_checks = 0;
    int n_pass   = 0;

    contrast_param_engine #(
        .CH_NUM    (3),
        .W         (8),
        .FRAC_W    (3),
        .MAX_TERMS (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_start (frame_start),
        .contrast_fp (contrast_fp),
        .cp_param    (cp_param),
        .invalid     (invalid),
        .err_ch      (err_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Non-adjacent form of val: digit d = +/-1 chosen so (v-d) is divisible by 4.
    function automatic logic [17:0] csd_terms(input int val);
        int v = val;
        int k = 0;
        bit ng;
        logic [17:0] r = '0;
        for (int i = 0; i <= 8; i++) begin
            if (v % 2 != 0) begin
                ng = (v % 4 == 3);
                if (k < 3) r[k*6 +: 6] = {1'b1, ng, 4'(i)};
                k++;
                v = ng ? (v + 1) / 2 : (v - 1) / 2;
            end else begin
                v = v / 2;
            end
        end
        return r;
    endfunction

    function automatic bit csd_ovf(input int val);
        int v = val;
        int k = 0;
        for (int i = 0; i <= 8; i++) begin
            if (v % 2 != 0) begin
                k++;
                v = (v % 4 == 3) ? (v + 1) / 2 : (v - 1) / 2;
            end else begin
                v = v / 2;
            end
        end
        return k > 3;
    endfunction

    // Transaction model: result of an accepted write lands 10 edges after acceptance.
    logic [7:0]  m_act_v [3];
    logic [7:0]  m_shd_v [3];
    logic [17:0] m_act_t [3];
    logic [17:0] m_shd_t [3];
    bit          m_pend  [3];
    int          m_cnt;
    logic [1:0]  m_ch;
    logic [7:0]  m_val;
    bit          m_inv;
    logic [1:0]  m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                m_act_v[c] <= 8'h08;
                m_shd_v[c] <= 8'h08;
                m_act_t[c] <= 18'h00023;
                m_shd_t[c] <= 18'h00023;
                m_pend[c]  <= 1'b0;
            end
            m_cnt <= 0;
            m_ch  <= '0;
            m_val <= '0;
            m_inv <= 1'b0;
            m_err <= '0;
        end else begin
            m_inv <= 1'b0;
            if (frame_start) begin
                for (int c = 0; c < 3; c++) begin
                    if (m_pend[c]) begin
                        m_act_v[c] <= m_shd_v[c];
                        m_act_t[c] <= m_shd_t[c];
                        m_pend[c]  <= 1'b0;
                    end
                end
            end
            if (m_cnt == 10) begin
                m_cnt <= 0;
                if (csd_ovf(int'(m_val)) || m_ch > 2'd2) begin
                    m_inv <= 1'b1;
                    m_err <= m_ch;
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        if (int'(m_ch) == c) begin
                            m_shd_v[c] <= m_val;
                            m_shd_t[c] <= csd_terms(int'(m_val));
                            m_pend[c]  <= 1'b1;
                        end
                    end
                end
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt + 1;
            end else if (wr_en) begin
                m_cnt <= 1;
                m_ch  <= wr_ch;
                m_val <= wr_data;
            end
        end
    end

    always @(negedge clk) begin
        chk("contrast_fp", 64'(contrast_fp), 64'({m_act_v[2], m_act_v[1], m_act_v[0]}));
        chk("cp_param", 64'(cp_param), 64'({m_act_t[2], m_act_t[1], m_act_t[0]}));
        chk("wr_ready", 64'(wr_ready), 64'(m_cnt == 0));
        chk("invalid", 64'(invalid), 64'(m_inv));
        chk("err_ch", 64'(err_ch), 64'(m_err));
    end

    task automatic do_write(input logic [1:0] ch, input logic [7:0] d, input bit inject,
                            output int low_cycles, output bit saw_inv, output logic [1:0] inv_ch);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        low_cycles = 0; saw_inv = 1'b0; inv_ch = '0;
        for (int i = 0; i < 30; i++) begin
            if (wr_ready) break;
            low_cycles++;
            wr_en = inject && (i == 3);
            wr_ch = 2'd0; wr_data = 8'hFF;
            @(negedge clk);
            wr_en = 1'b0;
            if (invalid) begin saw_inv = 1'b1; inv_ch = err_ch; end
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    initial begin
        int lc; bit si; logic [1:0] ic;

        chk("model_0x07", 64'(csd_terms(7)), 64'h008F0);
        chk("model_0x1F", 64'(csd_terms(31)), 64'h00970);
        chk("model_0xFF", 64'(csd_terms(255)), 64'h00A30);
        chk("model_ovf_0x55", 64'(csd_ovf(85)), 64'd1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_contrast", 64'(contrast_fp), 64'h080808);
        chk("reset_terms", 64'(cp_param), 64'({3{18'h00023}}));
        chk("reset_ready", 64'(wr_ready), 64'd1);
        chk("reset_invalid", 64'(invalid), 64'd0);

        do_write(2'd1, 8'h07, 1'b0, lc, si, ic);
        chk("busy_cycles", 64'(lc), 64'd10);
        chk("ch1_before_frame", 64'(contrast_fp[15:8]), 64'h08);
        pulse_frame();
        chk("ch1_val", 64'(contrast_fp[15:8]), 64'h07);
        chk("ch1_terms", 64'(cp_param[35:18]), 64'h008F0);

        do_write(2'd0, 8'h55, 1'b0, lc, si, ic);
        chk("ovf_invalid", 64'(si), 64'd1);
        chk("ovf_err_ch", 64'(ic), 64'd0);
        pulse_frame();
        chk("ovf_ch0_unchanged", 64'(contrast_fp[7:0]), 64'h08);

        do_write(2'd2, 8'h1F, 1'b0, lc, si, ic);
        pulse_frame();
        chk("ch2_terms_1F", 64'(cp_param[53:36]), 64'h00970);

        do_write(2'd3, 8'h07, 1'b0, lc, si, ic);
        chk("badch_invalid", 64'(si), 64'd1);
        chk("badch_err_ch", 64'(ic), 64'd3);

        do_write(2'd1, 8'h00, 1'b0, lc, si, ic);
        chk("zero_valid", 64'(si), 64'd0);
        pulse_frame();
        chk("zero_val", 64'(contrast_fp[15:8]), 64'h00);
        chk("zero_terms", 64'(cp_param[35:18]), 64'h0);

        // frame_start coincides with the DONE edge of a ch0 write.
        @(negedge clk);
        wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'h10;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (9) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("coincide_ch0_held", 64'(contrast_fp[7:0]), 64'h08);
        pulse_frame();
        chk("coincide_ch0_next", 64'(contrast_fp[7:0]), 64'h10);
        chk("coincide_terms", 64'(cp_param[17:0]), 64'h00024);

        do_write(2'd2, 8'h03, 1'b1, lc, si, ic);
        chk("inject_busy", 64'(lc), 64'd10);
        pulse_frame();
        chk("inject_ch2_terms", 64'(cp_param[53:36]), 64'h008B0);
        chk("inject_ch0_kept", 64'(contrast_fp[7:0]), 64'h10);

        do_write(2'd2, 8'hFF, 1'b0, lc, si, ic);
        pulse_frame();
        chk("ch2_terms_FF", 64'(cp_param[53:36]), 64'h00A30);

        // Reset during conversion.
        @(negedge clk);
        wr_en = 1'b1; wr_ch = 2'd1; wr_data = 8'h1F;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(wr_ready), 64'd1);
        chk("abort_contrast", 64'(contrast_fp), 64'h080808);
        chk("abort_terms", 64'(cp_param), 64'({3{18'h00023}}));
        si = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (invalid) si = 1'b1;
        end
        chk("abort_no_invalid", 64'(si), 64'd0);
        pulse_frame();
        chk("abort_no_commit", 64'(contrast_fp), 64'h080808);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
